// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and its companion detector.
// Holds the state encoding and the reset/target pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  // Reset pattern of the generator and target sequence of the detector.
  localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b1011;

  localparam int FRAME_CNT_W = 8;
  localparam int GAP_CNT_W   = 8;

  // Width needed to hold a bit index 0..w-1 (never narrower than one bit).
  function automatic int idx_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control and serial-output bundle of seq_pattern_gen.
// master = stimulus side, slave = generator side.
interface seq_pattern_gen_if
  import seq_pkg::*;
#(
  parameter int PATTERN_W = 4
) ();

  logic                   load;
  logic [PATTERN_W-1:0]   pattern_in;
  logic                   start;
  logic                   repeat_en;
  logic                   stop;
  logic                   sequence_out;
  logic                   valid_out;
  logic                   busy;
  logic                   done;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    output load, pattern_in, start, repeat_en, stop,
    input  sequence_out, valid_out, busy, done, frame_count
  );

  modport slave (
    input  load, pattern_in, start, repeat_en, stop,
    output sequence_out, valid_out, busy, done, frame_count
  );

endinterface

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag; used for the bit index and the gap count.
// Load has priority over decrement.
module seq_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts pattern_reg out MSB-first with a valid
// qualifier, one-shot or repeating with an optional idle gap between frames.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int                   PATTERN_W       = 4,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(SEQ_DEFAULT_PATTERN),
  parameter int                   GAP_CYCLES      = 0
) (
  input logic              clock,
  input logic              reset,
  seq_pattern_gen_if.slave bus
);

  localparam int                   IDX_W     = idx_width(PATTERN_W);
  localparam logic [IDX_W-1:0]     IDX_START = IDX_W'(PATTERN_W - 2);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [PATTERN_W-1:0]   pattern_q, pattern_d;
  logic                   seq_q, seq_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  // Set while the line carries bit 0, i.e. the next edge ends the frame.
  logic                   last_q, last_d;

  logic                   bit_ld, bit_dec, bit_zero;
  logic [IDX_W-1:0]       bit_idx;
  logic                   gap_ld, gap_dec, gap_zero;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic [PATTERN_W-1:0]   src;

  seq_bit_counter #(.WIDTH(IDX_W)) u_bit_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (bit_ld),
    .load_val_i (IDX_START),
    .dec_i      (bit_dec),
    .count_o    (bit_idx),
    .zero_o     (bit_zero)
  );

  seq_bit_counter #(.WIDTH(GAP_CNT_W)) u_gap_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (gap_ld),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .count_o    (gap_cnt),
    .zero_o     (gap_zero)
  );

  // A load in the start cycle transmits the freshly loaded word.
  assign src = bus.load ? bus.pattern_in : pattern_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    seq_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    frame_d   = frame_q;
    last_d    = last_q;
    bit_ld    = 1'b0;
    bit_dec   = 1'b0;
    gap_ld    = 1'b0;
    gap_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        last_d = 1'b0;
        if (bus.load) pattern_d = bus.pattern_in;
        if (bus.start) begin
          state_d = ST_SEND;
          seq_d   = src[PATTERN_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          bit_ld  = 1'b1;
        end
      end

      ST_SEND: begin
        busy_d = 1'b1;
        if (last_q) begin
          frame_d = frame_q + 1'b1;
          last_d  = 1'b0;
          if (bus.repeat_en && GAP_CYCLES == 0) begin
            seq_d   = pattern_q[PATTERN_W-1];
            valid_d = 1'b1;
            bit_ld  = 1'b1;
          end else if (bus.repeat_en) begin
            state_d = ST_GAP;
            gap_ld  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          seq_d   = pattern_q[bit_idx];
          valid_d = 1'b1;
          if (bit_zero) last_d  = 1'b1;
          else          bit_dec = 1'b1;
        end
      end

      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_zero) begin
          state_d = ST_SEND;
          seq_d   = pattern_q[PATTERN_W-1];
          valid_d = 1'b1;
          bit_ld  = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort wins over start, load and the end-of-frame bookkeeping.
    if (bus.stop) begin
      state_d   = ST_IDLE;
      pattern_d = pattern_q;
      seq_d     = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      frame_d   = frame_q;
      last_d    = 1'b0;
      bit_ld    = 1'b0;
      bit_dec   = 1'b0;
      gap_ld    = 1'b0;
      gap_dec   = 1'b0;
    end
  end

  // NOTE: pattern_q is a single config register, not a memory array, so it
  // takes its reset value along with the rest of the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= DEFAULT_PATTERN;
      seq_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      frame_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      seq_q     <= seq_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
    end
  end

  assign bus.sequence_out = seq_q;
  assign bus.valid_out    = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.frame_count  = frame_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: one instance without gap, one with
// a two-cycle gap, checked against a frame-level model of the output stream.
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam int W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  seq_pattern_gen_if #(.PATTERN_W(W)) bus_a ();
  seq_pattern_gen_if #(.PATTERN_W(W)) bus_b ();

  logic         load_r  [2];
  logic         start_r [2];
  logic         rep_r   [2];
  logic         stop_r  [2];
  logic [W-1:0] pin_r   [2];

  assign bus_a.load       = load_r[0];
  assign bus_a.start      = start_r[0];
  assign bus_a.repeat_en  = rep_r[0];
  assign bus_a.stop       = stop_r[0];
  assign bus_a.pattern_in = pin_r[0];
  assign bus_b.load       = load_r[1];
  assign bus_b.start      = start_r[1];
  assign bus_b.repeat_en  = rep_r[1];
  assign bus_b.stop       = stop_r[1];
  assign bus_b.pattern_in = pin_r[1];

  seq_pattern_gen #(.PATTERN_W(W), .DEFAULT_PATTERN(4'b1011), .GAP_CYCLES(0)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  seq_pattern_gen #(.PATTERN_W(W), .DEFAULT_PATTERN(4'b1011), .GAP_CYCLES(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct packed {
    logic       seq;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int         sel;
    logic [3:0] pat;
    bit         use_load;
    int         nframes;
    int         stop_at;
    logic [3:0] exp_cap;
    logic [7:0] exp_delta;
    bit         exp_done;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] model_pat [2];
  logic [7:0]   model_fc  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int s);
    if (s == 0)
      return {bus_a.sequence_out, bus_a.valid_out, bus_a.busy, bus_a.done, bus_a.frame_count};
    return {bus_b.sequence_out, bus_b.valid_out, bus_b.busy, bus_b.done, bus_b.frame_count};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      load_r[i]  = 1'b0;
      start_r[i] = 1'b0;
      rep_r[i]   = 1'b0;
      stop_r[i]  = 1'b0;
      pin_r[i]   = '0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_pat[i] = 4'b1011;
      model_fc[i]  = 8'd0;
    end
  endtask

  // Expected stream: nframes copies of the pattern MSB-first, gap zeros between
  // them, then a done pulse and idle; a stop truncates to idle one cycle later.
  // repeat_en is only pinned on last-bit cycles and randomised elsewhere; stray
  // start/load pulses are thrown in while the generator is busy.
  task automatic run_frames(input string tag, input int s, input logic [W-1:0] p,
                            input bit use_load, input int nframes, input int stop_at,
                            output logic [3:0] cap, output logic [7:0] fc_delta,
                            output bit done_seen);
    obs_t         exp_q[$];
    int           req_q[$];
    logic [7:0]   fc;
    logic [7:0]   fc_start;
    logic [W-1:0] pat;
    obs_t         o;
    int           gap;
    int           nvalid;

    gap = (s == 0) ? 0 : 2;
    pat = use_load ? p : model_pat[s];
    if (use_load) model_pat[s] = p;
    fc = model_fc[s];
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < W; i++) begin
        exp_q.push_back({pat[W-1-i], 1'b1, 1'b1, 1'b0, fc});
        req_q.push_back((i == W-1) ? ((f < nframes-1) ? 1 : 0) : -1);
      end
      fc = fc + 8'd1;
      if (f < nframes-1) begin
        for (int g = 0; g < gap; g++) begin
          exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, fc});
          req_q.push_back(-1);
        end
      end
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, fc});
    req_q.push_back(-1);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, fc});
    req_q.push_back(-1);
    if (stop_at >= 0) begin
      while (exp_q.size() > stop_at + 1) begin
        void'(exp_q.pop_back());
        void'(req_q.pop_back());
      end
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, exp_q[stop_at].fc});
      req_q.push_back(-1);
    end
    model_fc[s] = exp_q[exp_q.size()-1].fc;

    fc_start   = get_obs(s).fc;
    cap        = '0;
    nvalid     = 0;
    done_seen  = 1'b0;
    pin_r[s]   = use_load ? p : W'($urandom);
    load_r[s]  = use_load;
    start_r[s] = 1'b1;
    rep_r[s]   = 1'($urandom_range(0, 1));
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      o = get_obs(s);
      check($sformatf("%s cyc%0d", tag, k), 32'(o), 32'(exp_q[k]));
      if (o.valid && nvalid < 4) begin
        cap = {cap[2:0], o.seq};
        nvalid++;
      end
      done_seen |= o.done;
      start_r[s] = 1'b0;
      load_r[s]  = 1'b0;
      stop_r[s]  = (k == stop_at);
      rep_r[s]   = (req_q[k] >= 0) ? (req_q[k] == 1) : 1'($urandom_range(0, 1));
      if (exp_q[k].busy && $urandom_range(0, 3) == 0) begin
        start_r[s] = 1'b1;
        load_r[s]  = 1'b1;
        pin_r[s]   = W'($urandom);
      end
    end
    fc_delta = o.fc - fc_start;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vt[10];
    logic [3:0] cap;
    logic [7:0] delta;
    bit         dseen;
    obs_t       o;
    logic [3:0] hist;
    int         hits;
    int         nv;
    logic [7:0] fc_before;

    clear_inputs();
    model_reset();
    reset = 1'b1;
    #12;
    check("reset dut_a", 32'(get_obs(0)), 32'd0);
    check("reset dut_b", 32'(get_obs(1)), 32'd0);
    reset = 1'b0;

    //        sel pat      load nfr stop  cap      delta done
    vt[0] = '{0, 4'b0000, 0,   1,  -1,   4'b1011, 8'd1, 1};
    vt[1] = '{0, 4'b0110, 1,   1,  -1,   4'b0110, 8'd1, 1};
    vt[2] = '{0, 4'b0000, 0,   1,  -1,   4'b0110, 8'd1, 1};
    vt[3] = '{0, 4'b1011, 1,   3,  -1,   4'b1011, 8'd3, 1};
    vt[4] = '{1, 4'b0000, 0,   2,  -1,   4'b1011, 8'd2, 1};
    vt[5] = '{1, 4'b1100, 1,   2,   5,   4'b1100, 8'd1, 0};
    vt[6] = '{0, 4'b0000, 0,   1,   1,   4'b0010, 8'd0, 0};
    vt[7] = '{1, 4'b0001, 1,   1,  -1,   4'b0001, 8'd1, 1};
    vt[8] = '{1, 4'b1011, 1,   1,   3,   4'b1011, 8'd0, 0};
    vt[9] = '{0, 4'b1001, 1,   2,   3,   4'b1001, 8'd0, 0};

    for (int i = 0; i < 10; i++) begin
      run_frames($sformatf("vec%0d", i), vt[i].sel, vt[i].pat, vt[i].use_load,
                 vt[i].nframes, vt[i].stop_at, cap, delta, dseen);
      check($sformatf("vec%0d bits", i), 32'(cap), 32'(vt[i].exp_cap));
      check($sformatf("vec%0d frames", i), 32'(delta), 32'(vt[i].exp_delta));
      check($sformatf("vec%0d done", i), 32'(dseen), 32'(vt[i].exp_done));
    end

    // Loopback into a 1011 detector: one hit per transmitted frame.
    fc_before  = model_fc[0];
    pin_r[0]   = 4'b1011;
    load_r[0]  = 1'b1;
    start_r[0] = 1'b1;
    rep_r[0]   = 1'b1;
    hist = '0;
    hits = 0;
    nv   = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      load_r[0]  = 1'b0;
      start_r[0] = 1'b0;
      o = get_obs(0);
      if (o.valid) begin
        hist = {hist[2:0], o.seq};
        nv++;
        if (nv >= 4 && hist == 4'b1011) hits++;
      end
    end
    check("loopback hits", 32'(hits), 32'd3);
    check("loopback valid run", 32'(nv), 32'd12);
    tick();
    tick();
    check("loopback frames", 32'(get_obs(0).fc), 32'(fc_before + 8'd3));

    // Asynchronous reset in the middle of a frame, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("async reset dut_a", 32'(get_obs(0)), 32'd0);
    check("async reset dut_b", 32'(get_obs(1)), 32'd0);
    clear_inputs();
    tick();
    tick();
    #2;
    reset = 1'b0;
    model_reset();

    for (int r = 0; r < 24; r++) begin
      int s;
      int nf;
      int busy_len;
      int st;
      s        = $urandom_range(0, 1);
      nf       = $urandom_range(1, 3);
      busy_len = nf * W + (nf - 1) * ((s == 0) ? 0 : 2);
      st       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, busy_len - 1) : -1;
      run_frames($sformatf("rnd%0d", r), s, W'($urandom), 1'($urandom_range(0, 1)),
                 nf, st, cap, delta, dseen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
